counter_arbiter: RTL and testbench

- Schedules one shared 8-bit loadable/incrementing counter between NREQ requesters.
- Each requester issues one command: LOAD a value, or INC the counter N times.
- The block grants requesters round-robin, drives the counter's data_in/ld/inc controls, and returns the post-operation counter value to the winner.
- Sits between requester agents and the counter instance; it is the only driver of the counter's ld/inc/data_in.

---
 rtl/counter_arb_pkg.sv | 25 ++
 rtl/counter_arbiter_if.sv | 31 +++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/counter_arbiter.sv | 147 ++++++++++++++
 tb/tb_counter_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_arb_pkg.sv
// rtl/counter_arb_pkg.sv - shared types and defaults for the counter arbiter
// Purpose: opcode and FSM state enums, default sizes, index-width helper.
// Ports: none (package).
package counter_arb_pkg;

  localparam int DEF_W    = 8;
  localparam int DEF_NREQ = 4;

  typedef enum logic {
    OP_LOAD = 1'b0,
    OP_INC  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } state_e;

  // Width of a requester index; never below one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/counter_arbiter_if.sv
// rtl/counter_arbiter_if.sv - requester command/response bus
// Purpose: bundles the per-requester command handshake and the response pulses.
// Ports (modport master = requester side, slave = arbiter side):
//   req_valid/req_op/req_data  command from requesters (slice i = [i*W +: W])
//   req_ready                  one-hot accept pulse
//   rsp_valid/rsp_q            one-hot completion pulse and counter value
interface counter_arbiter_if
  import counter_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_op;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_q;

  modport master (
    output req_valid, req_op, req_data,
    input  req_ready, rsp_valid, rsp_q
  );

  modport slave (
    input  req_valid, req_op, req_data,
    output req_ready, rsp_valid, rsp_q
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker
// Purpose: first set request at or after ptr, wrapping past NREQ-1.
// Ports:
//   req        request vector
//   ptr        highest-priority index this round
//   gnt        one-hot grant (zero when nothing requests)
//   idx        binary index of the grant
//   any_valid  at least one request set
module rr_arbiter
  import counter_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any_valid
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic              found;
  int                s;

  always_comb begin
    // Doubling the vector makes the wrap a plain shift: rot[k] = req[(ptr+k) mod NREQ].
    dbl   = {req, req};
    rot   = NREQ'(dbl >> ptr);
    found = 1'b0;
    idx   = '0;
    s     = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        s     = int'(ptr) + k;
        if (s >= NREQ) s = s - NREQ;
        idx   = IW'(s);
      end
    end
    gnt       = found ? (NREQ'(1) << idx) : '0;
    any_valid = |req;
  end

endmodule

// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - round-robin scheduler for one shared load/inc counter
// Purpose: accepts one LOAD or INC-N command at a time, drives the counter
//          controls from registers, and returns the post-operation value.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   bus (slave)              requester commands and responses
//   busy                     high whenever not idle
//   cntr_data_in/ld/inc      counter controls (registered, mutually exclusive ld/inc)
//   cntr_q                   counter value
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic               clk,
  input  logic               rst,
  counter_arbiter_if.slave   bus,
  output logic               busy,
  output logic [W-1:0]       cntr_data_in,
  output logic               cntr_ld,
  output logic               cntr_inc,
  input  logic [W-1:0]       cntr_q
);

  localparam int IW = idx_w(NREQ);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    din_q, din_d;
  logic            ld_q, ld_d;
  logic            inc_q, inc_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic [W-1:0]    arb_opnd;
  op_e             arb_op;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .gnt       (arb_gnt),
    .idx       (arb_idx),
    .any_valid (arb_any)
  );

  assign arb_opnd = bus.req_data[int'(arb_idx)*W +: W];
  assign arb_op   = op_e'(bus.req_op[arb_idx]);

  // Next-state and next-output decode. Control outputs are computed one cycle
  // ahead so the registered values line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    rem_d       = rem_q;
    din_d       = din_q;
    ld_d        = 1'b0;
    inc_d       = 1'b0;
    rsp_valid_d = '0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_d = arb_gnt;
          op_d  = arb_op;
          ptr_d = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
          if (arb_op == OP_LOAD) begin
            din_d   = arb_opnd;
            ld_d    = 1'b1;
            state_d = ISSUE;
          end else if (arb_opnd != '0) begin
            rem_d   = arb_opnd;
            inc_d   = 1'b1;
            state_d = ISSUE;
          end else begin
            // INC 0: nothing to issue, respond next cycle.
            state_d     = SETTLE;
            rsp_valid_d = arb_gnt;
          end
        end
      end
      ISSUE: begin
        if (op_q == OP_LOAD) begin
          state_d     = SETTLE;
          rsp_valid_d = gnt_q;
        end else begin
          rem_d = rem_q - W'(1);
          if (rem_q == W'(1)) begin
            state_d     = SETTLE;
            rsp_valid_d = gnt_q;
          end else begin
            inc_d = 1'b1;
          end
        end
      end
      SETTLE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= OP_LOAD;
      ptr_q       <= '0;
      gnt_q       <= '0;
      rem_q       <= '0;
      din_q       <= '0;
      ld_q        <= 1'b0;
      inc_q       <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      rem_q       <= rem_d;
      din_q       <= din_d;
      ld_q        <= ld_d;
      inc_q       <= inc_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Accept pulse is the only combinational output; reset masks it because the
  // async reset forces IDLE while requests may still be held.
  assign bus.req_ready = (rst && state_q == IDLE) ? arb_gnt : '0;
  assign bus.rsp_valid = rsp_valid_q;
  // The counter updates on the edge that enters SETTLE, so its current value
  // is the post-operation result.
  assign bus.rsp_q     = (|rsp_valid_q) ? cntr_q : '0;
  assign busy          = busy_q;
  assign cntr_ld       = ld_q;
  assign cntr_inc      = inc_q;
  assign cntr_data_in  = din_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - self-checking bench for counter_arbiter
module tb_counter_arbiter;
  import counter_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       busy, cntr_ld, cntr_inc;
  logic [7:0] cntr_data_in;
  logic [7:0] cnt_q = 8'h00;

  always #5 clk = ~clk;

  counter_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  counter_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .cntr_data_in (cntr_data_in),
    .cntr_ld      (cntr_ld),
    .cntr_inc     (cntr_inc),
    .cntr_q       (cnt_q)
  );

  // Shared counter instance driven by the arbiter.
  always @(posedge clk) begin
    if (cntr_ld) cnt_q <= cntr_data_in;
    else if (cntr_inc) cnt_q <= cnt_q + 8'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         idx;
    int         cyc;
    logic [7:0] val;
  } ev_t;

  ev_t acc_log[$];
  ev_t rsp_log[$];
  ev_t ld_log[$];
  int  inc_cnt = 0;
  logic [NREQ-1:0] pend_clr = '0;

  // Reference model: one outstanding command with a timeline measured from
  // its acceptance cycle, plus an abstract counter value.
  bit         s_act = 0;
  int         s_t, s_idx, s_n, s_lat;
  bit         s_op;
  int         m_ptr = 0;
  logic [7:0] m_cnt = 8'h00;
  logic [7:0] m_din = 8'h00;
  int         accepts[NREQ];
  int         dones[NREQ];
  int         aborted[NREQ];

  always @(negedge clk) begin
    int              g, c;
    logic [NREQ-1:0] e_rdy, e_rsp;
    logic            e_ld, e_inc, e_busy;
    logic [7:0]      e_q;
    logic [NREQ-1:0] rv;

    rv = bus.req_valid;
    g  = -1;

    chk("ld_inc_exclusive", {31'd0, cntr_ld & cntr_inc}, 0);
    chk("ready_onehot0", {31'd0, $onehot0(bus.req_ready)}, 1);
    chk("rsp_onehot0", {31'd0, $onehot0(bus.rsp_valid)}, 1);

    // Observation logs used by the directed checks.
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_ready[i]) begin
        acc_log.push_back('{i, cyc, 8'h00});
        pend_clr[i] = 1'b1;
      end
      if (bus.rsp_valid[i]) rsp_log.push_back('{i, cyc, bus.rsp_q});
    end
    if (cntr_ld) ld_log.push_back('{0, cyc, cntr_data_in});
    if (cntr_inc) inc_cnt++;

    if (!rst) begin
      if (s_act) aborted[s_idx]++;
      s_act = 0;
      m_ptr = 0;
      m_din = 8'h00;
      chk("rst_req_ready", {28'd0, bus.req_ready}, 0);
      chk("rst_rsp_valid", {28'd0, bus.rsp_valid}, 0);
      chk("rst_rsp_q", {24'd0, bus.rsp_q}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_ld", {31'd0, cntr_ld}, 0);
      chk("rst_inc", {31'd0, cntr_inc}, 0);
      chk("rst_data_in", {24'd0, cntr_data_in}, 0);
    end else begin
      e_rdy  = '0;
      e_rsp  = '0;
      e_ld   = 1'b0;
      e_inc  = 1'b0;
      e_q    = 8'h00;
      e_busy = s_act;
      if (s_act) begin
        c = cyc - s_t;
        if (s_op == 1'b0) e_ld = (c == 1);
        else e_inc = (c >= 1 && c <= s_n);
        if (c == s_lat) begin
          e_rsp[s_idx] = 1'b1;
          e_q = m_cnt;
        end
      end else begin
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && rv[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        if (g >= 0) e_rdy[g] = 1'b1;
      end

      chk("req_ready", {28'd0, bus.req_ready}, {28'd0, e_rdy});
      chk("rsp_valid", {28'd0, bus.rsp_valid}, {28'd0, e_rsp});
      chk("cntr_ld", {31'd0, cntr_ld}, {31'd0, e_ld});
      chk("cntr_inc", {31'd0, cntr_inc}, {31'd0, e_inc});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("cntr_data_in", {24'd0, cntr_data_in}, {24'd0, m_din});
      if (|e_rsp) chk("rsp_q", {24'd0, bus.rsp_q}, {24'd0, e_q});

      if (e_ld) m_cnt = m_din;
      if (e_inc) m_cnt = m_cnt + 8'd1;
      if (|e_rsp) begin
        s_act = 0;
        dones[s_idx]++;
      end
      if (g >= 0) begin
        s_act = 1;
        s_t   = cyc;
        s_idx = g;
        s_op  = bus.req_op[g];
        s_n   = int'(bus.req_data[g*8 +: 8]);
        s_lat = s_op ? s_n + 1 : 2;
        m_ptr = (g + 1) % NREQ;
        if (!s_op) m_din = bus.req_data[g*8 +: 8];
        accepts[g]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (pend_clr[i]) begin
        bus.req_valid[i] = 1'b0;
        pend_clr[i] = 1'b0;
      end
    end
  endtask

  task automatic post(input int i, input bit op, input logic [7:0] d);
    bus.req_valid[i]       = 1'b1;
    bus.req_op[i]          = op;
    bus.req_data[i*8 +: 8] = d;
  endtask

  task automatic quiesce(input int budget);
    int n = 0;
    while ((bus.req_valid != '0 || busy || s_act) && n < budget) begin
      tick();
      n++;
    end
    chk("quiesce_timeout", {31'd0, n < budget}, 1);
    tick();
  endtask

  task automatic wait_acc(input int base, input int budget);
    int n = 0;
    while (acc_log.size() <= base && n < budget) begin
      tick();
      n++;
    end
    chk("accept_timeout", {31'd0, n < budget}, 1);
  endtask

  task automatic check_last(input string name, input int idx, input int lat, input logic [7:0] val);
    ev_t a, r;
    a = acc_log[acc_log.size()-1];
    r = rsp_log[rsp_log.size()-1];
    chk({name, "_acc_idx"}, a.idx, idx);
    chk({name, "_rsp_idx"}, r.idx, idx);
    chk({name, "_latency"}, r.cyc - a.cyc, lat);
    chk({name, "_rsp_q"}, {24'd0, r.val}, {24'd0, val});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    ev_t a, r;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      accepts[i] = 0;
      dones[i]   = 0;
      aborted[i] = 0;
    end

    // Reset with a request held: nothing may be accepted.
    post(2, 1'b0, 8'h77);
    repeat (3) tick();
    chk("reset_busy_lit", {31'd0, busy}, 0);
    chk("reset_ready_lit", {28'd0, bus.req_ready}, 0);
    chk("reset_data_in_lit", {24'd0, cntr_data_in}, 0);
    bus.req_valid = '0;
    rst = 1'b1;
    repeat (2) tick();

    // Reset mid-INC: req0 INC 10, reset in the 4th inc cycle.
    base = acc_log.size();
    post(0, 1'b1, 8'd10);
    wait_acc(base, 20);
    repeat (3) tick();
    chk("inc_before_rst", {31'd0, cntr_inc}, 1);
    base = rsp_log.size();
    rst = 1'b0;
    #1;
    chk("rst_inc_immediate", {31'd0, cntr_inc}, 0);
    chk("rst_busy_immediate", {31'd0, busy}, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("abort_no_rsp", rsp_log.size(), base);
    chk("abort_cnt_value", {24'd0, cnt_q}, 3);

    // After reset the pointer restarts at 0.
    base = rsp_log.size();
    post(0, 1'b0, 8'h12);
    post(1, 1'b0, 8'h34);
    quiesce(40);
    chk("post_rst_first_idx", rsp_log[base].idx, 0);
    chk("post_rst_first_val", {24'd0, rsp_log[base].val}, 8'h12);
    chk("post_rst_second_idx", rsp_log[base+1].idx, 1);

    // Single LOAD.
    post(1, 1'b0, 8'h5A);
    quiesce(20);
    check_last("load", 1, 2, 8'h5A);
    a = acc_log[acc_log.size()-1];
    chk("load_ld_cycle", ld_log[ld_log.size()-1].cyc - a.cyc, 1);
    chk("load_ld_data", {24'd0, ld_log[ld_log.size()-1].val}, 8'h5A);

    // INC burst wrapping past 0xFF.
    post(2, 1'b0, 8'hFE);
    quiesce(20);
    inc_cnt = 0;
    post(2, 1'b1, 8'd3);
    quiesce(20);
    check_last("inc_wrap", 2, 4, 8'h01);
    chk("inc_wrap_pulses", inc_cnt, 3);

    // INC 0.
    post(3, 1'b0, 8'h33);
    quiesce(20);
    inc_cnt = 0;
    post(3, 1'b1, 8'd0);
    quiesce(20);
    check_last("inc0", 3, 1, 8'h33);
    chk("inc0_pulses", inc_cnt, 0);

    // Round-robin fairness with req0 re-asserting right after its response.
    base = rsp_log.size();
    for (int i = 0; i < NREQ; i++) post(i, 1'b0, 8'(i * 8'h11));
    n = 0;
    while (rsp_log.size() <= base && n < 20) begin
      tick();
      n++;
    end
    chk("rr_first_rsp_timeout", {31'd0, n < 20}, 1);
    post(0, 1'b0, 8'h44);
    quiesce(60);
    for (int k = 0; k < 5; k++) begin
      r = rsp_log[base + k];
      chk("rr_order_idx", r.idx, k % 4);
      chk("rr_order_val", {24'd0, r.val}, (k == 4) ? 32'h44 : 32'(k * 8'h11));
    end

    for (int i = 0; i < NREQ; i++)
      chk("accept_vs_response", accepts[i], dones[i] + aborted[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
